// File: rtl/dpic_mem_if.sv
// dpic_mem_if: request, write-beat, read-beat and write-response channels of the memory port,
// plus the host byte store behind the pmem_read/pmem_write calls.
interface dpic_mem_if #(
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [63:0]           req_addr;
  logic [LEN_W-1:0]      req_len;
  logic                  w_valid;
  logic                  w_ready;
  logic [DATA_W-1:0]     w_data;
  logic [DATA_W/8-1:0]   w_mask;
  logic                  w_last;
  logic                  r_valid;
  logic                  r_ready;
  logic [DATA_W-1:0]     r_data;
  logic                  r_last;
  logic                  b_valid;
  logic                  b_ready;
  logic                  b_err;

  logic [7:0]  host_mem [logic [63:0]];
  logic [63:0] log_addr [$];
  int          log_len  [$];

  // Bytes never written read back as a fixed function of their address.
  function automatic logic [7:0] host_byte(input logic [63:0] a);
    if (host_mem.exists(a)) return host_mem[a];
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [63:0] pmem_read(input logic [63:0] addr, input int len);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < len && i < 8; i++) v[8*i +: 8] = host_byte(addr + 64'(i));
    return v;
  endfunction

  function automatic void pmem_write(input logic [63:0] addr, input int len, input logic [63:0] data);
    for (int i = 0; i < len && i < 8; i++) host_mem[addr + 64'(i)] = data[8*i +: 8];
    log_addr.push_back(addr);
    log_len.push_back(len);
  endfunction

  modport slave (
    input  req_valid, req_write, req_addr, req_len, w_valid, w_data, w_mask, w_last, r_ready, b_ready,
    output req_ready, w_ready, r_valid, r_data, r_last, b_valid, b_err,
    import pmem_read, import pmem_write
  );

  modport master (
    output req_valid, req_write, req_addr, req_len, w_valid, w_data, w_mask, w_last, r_ready, b_ready,
    input  req_ready, w_ready, r_valid, r_data, r_last, b_valid, b_err
  );
endinterface

// File: rtl/dpic_mem_port.sv
// dpic_mem_port: handshaked burst memory model with access latency and byte masks over pmem_read/pmem_write.
// Define DPIC_MEM_TRACE_EN to print one line per host-memory call.
module dpic_mem_port #(
  parameter int DATA_W  = 64,
  parameter int LATENCY = 2,
  parameter int LEN_W   = 8
) (
  input logic       clock,
  input logic       reset_n,
  dpic_mem_if.slave bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int LANES = DATA_W / 64;
  localparam int LG    = $clog2(BYTES);
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LAT, S_RDATA, S_WDATA, S_BRESP} state_t;

  state_t            state_q, state_d;
  logic [63:0]       base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              write_q, write_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] r_data_q;
  logic              rd_load, wr_fire;
  logic [63:0]       rd_addr, wr_addr;

  function automatic logic [63:0] beat_addr(input logic [63:0] base, input logic [LEN_W-1:0] idx);
    return base + (64'(idx) << LG);
  endfunction

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    beat_d  = beat_q;
    lat_d   = lat_q;
    write_d = write_q;
    err_d   = err_q;
    rd_load = 1'b0;
    rd_addr = beat_addr(base_q, beat_q);
    wr_fire = 1'b0;
    wr_addr = beat_addr(base_q, beat_q);
    case (state_q)
      S_IDLE: if (bus.req_valid) begin
        base_d  = bus.req_addr & ~64'(BYTES - 1);
        len_d   = bus.req_len;
        write_d = bus.req_write;
        beat_d  = '0;
        err_d   = 1'b0;
        lat_d   = LAT_W'(LATENCY > 0 ? LATENCY - 1 : 0);
        if (LATENCY == 0) begin
          state_d = bus.req_write ? S_WDATA : S_RDATA;
          rd_load = !bus.req_write;
          rd_addr = base_d;
        end else begin
          state_d = S_LAT;
        end
      end
      S_LAT: begin
        if (lat_q == '0) begin
          state_d = write_q ? S_WDATA : S_RDATA;
          rd_load = !write_q;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      S_RDATA: if (bus.r_ready) begin
        if (beat_q == len_q) begin
          state_d = S_IDLE;
        end else begin
          beat_d  = beat_q + LEN_W'(1);
          rd_load = 1'b1;
          rd_addr = beat_addr(base_q, beat_d);
        end
      end
      // The beat count alone ends the burst; a disagreeing w_last only marks the response.
      S_WDATA: if (bus.w_valid) begin
        wr_fire = 1'b1;
        if (bus.w_last != (beat_q == len_q)) err_d = 1'b1;
        if (beat_q == len_q) state_d = S_BRESP;
        else                 beat_d  = beat_q + LEN_W'(1);
      end
      S_BRESP: if (bus.b_ready) begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.w_ready   = (state_q == S_WDATA);
  assign bus.r_valid   = (state_q == S_RDATA);
  assign bus.r_last    = (state_q == S_RDATA) && (beat_q == len_q);
  assign bus.r_data    = r_data_q;
  assign bus.b_valid   = (state_q == S_BRESP);
  assign bus.b_err     = (state_q == S_BRESP) && err_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      lat_q    <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      r_data_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
      write_q <= write_d;
      err_q   <= err_d;
      if (rd_load)
        for (int k = 0; k < LANES; k++)
          r_data_q[64*k +: 64] <= bus.pmem_read(rd_addr + 64'(8*k), 8);
      // Full lanes go out as one 8-byte call; partial lanes as ascending single-byte calls.
      if (wr_fire)
        for (int k = 0; k < LANES; k++) begin
          if (bus.w_mask[8*k +: 8] == 8'hFF)
            bus.pmem_write(wr_addr + 64'(8*k), 8, bus.w_data[64*k +: 64]);
          else
            for (int b = 0; b < 8; b++)
              if (bus.w_mask[8*k + b])
                bus.pmem_write(wr_addr + 64'(8*k + b), 1, bus.w_data[64*k +: 64] >> (8*b));
        end
    end
  end

`ifdef DPIC_MEM_TRACE_EN
  logic [63:0] cyc_q;
  logic        trc_rd_q;
  logic [63:0] trc_addr_q;

  // Read data only exists after the edge, so read calls are reported one cycle late with their own cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cyc_q      <= '0;
      trc_rd_q   <= 1'b0;
      trc_addr_q <= '0;
    end else begin
      cyc_q      <= cyc_q + 64'd1;
      trc_rd_q   <= rd_load;
      trc_addr_q <= rd_addr;
      if (trc_rd_q)
        for (int k = 0; k < LANES; k++)
          $display("[%0d] R addr=%h len=8 data=%h", cyc_q - 64'd1, trc_addr_q + 64'(8*k), r_data_q[64*k +: 64]);
      if (wr_fire)
        for (int k = 0; k < LANES; k++)
          for (int b = 0; b < 8; b++)
            if ((bus.w_mask[8*k +: 8] == 8'hFF) ? (b == 0) : bus.w_mask[8*k + b])
              $display("[%0d] W addr=%h len=%0d data=%h", cyc_q, wr_addr + 64'(8*k + b),
                       (bus.w_mask[8*k +: 8] == 8'hFF) ? 8 : 1, bus.w_data[64*k +: 64] >> (8*b));
    end
  end
`endif
endmodule

// File: doc/dpic_mem_port.md
# dpic_mem_port

Parametrised, handshaked simulation memory model for the NPC playground. It wraps the DPI-C `pmem_read`/`pmem_write` host memory behind ready/valid request, write-data, read-response and write-response channels. It adds configurable access latency, bursts, wide data and arbitrary byte masks, so cache and LSU blocks can be verified against realistic bus timing instead of a zero-latency combinational port.

## Interface
- `DATA_W`, 64: beat width in bits; multiple of 64 (64, 128, 256).
- `LATENCY`, 2: idle cycles between request acceptance and the first data beat; 0 allowed.
- `LEN_W`, 8: width of the burst length field.

- `clock`  in  1  clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request valid.
- `req_ready`  out  1  request accepted when high with `req_valid`.
- `req_write`  in  1  1 = write burst, 0 = read burst.
- `req_addr`  in  64  byte address; low log2(DATA_W/8) bits ignored (forced aligned).
- `req_len`  in  LEN_W  beats minus one.
- `w_valid` / `w_ready`  in / out  1  write-beat handshake.
- `w_data`  in  DATA_W  write beat.
- `w_mask`  in  DATA_W/8  byte enables.
- `w_last`  in  1  sender's last-beat marker.
- `r_valid` / `r_ready`  out / in  1  read-beat handshake.
- `r_data`  out  DATA_W  read beat.
- `r_last`  out  1  final read beat.
- `b_valid` / `b_ready`  out / in  1  write-response handshake.
- `b_err`  out  1  `w_last` disagreed with `req_len` on some beat.

## Operation
- FSM states: IDLE, LAT, RDATA, WDATA, BRESP.
- IDLE: `req_ready`=1. On handshake, latch address, len and dir. Go to LAT, or straight to the data state if LATENCY=0.
- LAT: down-counter from LATENCY; at 0 go to RDATA (read) or WDATA (write).
- Beat address = aligned base + i·(DATA_W/8), for i = 0..len. Wraps modulo 2^64.
- RDATA
  - On entering a beat, fill `r_data` in the sequential block. Issue one `pmem_read(addr+8k, 8)` per 64-bit lane k; lane k drives `r_data[64k+63:64k]`.
  - `r_valid` is held and `r_data` stays stable until `r_ready`. `r_last`=1 on beat len.
  - After the last handshake, return to IDLE.
- WDATA
  - `w_ready`=1. Each accepted beat is written at that clock edge.
  - Per 64-bit lane: lane mask 0xFF → one `pmem_write(addr, 8, lane)`. Mask 0x00 → no call. Otherwise one `pmem_write(addr+b, 1, lane>>8b)` per set byte b, in ascending b. Every mask is honoured; nothing is ever written to address 0 as a fallback.
  - `w_last` must equal (beat==len); any mismatch sets a sticky err flag. The beat count alone decides termination.
  - After beat len go to BRESP.
- BRESP: `b_valid`=1 and `b_err`=flag until `b_ready`, then go to IDLE and clear the flag.
- Only one burst is outstanding at a time. `req_ready`=0 outside IDLE.

## Timing
- Reset values: `req_ready`=1, and `w_ready`, `r_valid`, `r_last`, `b_valid`, `b_err` all 0. `r_data`=0. FSM in IDLE, counters 0.
- Request handshake at edge T:
  - Read: first `r_valid` is high in the cycle after edge T+LATENCY, i.e. LATENCY+1 cycles after the request.
  - Write: `w_ready` rises at the same point.
- With `r_ready` held high, reads stream one beat per cycle with no bubbles.
- With `w_valid` held high, writes are accepted one beat per cycle.
- `b_valid` rises one cycle after the last write handshake.
- A read issued after a write's `b_valid` handshake observes that write.
- `reset_n` low mid-burst forces IDLE immediately (asynchronously) and drops all valids. DPI writes already performed are not undone, and remaining beats are abandoned.
- Minimum read burst occupancy: LATENCY+len+2 cycles including the IDLE accept cycle.

## Configuration
- `DPIC_MEM_TRACE_EN`
  - Defined: `$display` one line per DPI call, giving cycle count, R/W, address, len and data in hex.
  - Undefined: no display statements are compiled in. Handshake timing and DPI call sequence are identical in both builds.

## Test plan
- Single read: LATENCY=2, addr 0x8000_0008, len 0, `r_ready`=1. Expect `r_valid` 3 cycles after accept, `r_data` = host word at 0x8000_0008, `r_last`=1.
- Write then read: write burst len 3 at 0x8000_0100, data 0x11..0x44, mask 0xFF. Expect 4 `pmem_write(…,8,…)` calls at +0/+8/+16/+24 and `b_err`=0. Read-back returns 0x11, 0x22, 0x33, 0x44.
- Sparse mask: lane mask 0b1010_0101, data 0x8877665544332211. Expect 4 byte writes: 0x11@+0, 0x33@+2, 0x66@+5, 0x88@+7. Other bytes unchanged.
- Backpressure: read len 2 with `r_ready` toggling 1,0,0,1,1. Expect `r_data` stable while stalled, 3 beats total, `r_last` only on the third.
- Length error: write len 1 with `w_last`=1 on beat 0. Expect both beats written, `b_valid` with `b_err`=1, and the next burst's `b_err`=0.
- Reset mid-burst: drop `reset_n` during read beat 1 of len 3. Expect all valids 0 immediately and `req_ready`=1. After release, a new request completes normally.
